ifu_fetch_stage: RTL and testbench
==================================

Name: ifu_fetch_stage

Overview:
- Instruction-fetch stage placed directly upstream of the instruction memory.
- Owns the PC register and computes the next PC: sequential, branch, jump-immediate, or jump-register.
- Drives the IM 12-bit word address and captures the returned instruction into an F/D pipeline register for the decoder.
- Supports a decode stall and squashes the wrong-path fetch on redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address mapped to IM word 0.
- IM_AW, 12, IM word-address width; the IM window is 4*2^IM_AW bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold the PC and the F/D register.
- npc_op  in  2  redirect request from D: 00 SEQ, 01 BR, 10 J, 11 JR.
- br_cond  in  1  branch condition resolved in D; used only when npc_op=BR.
- d_pc  in  32  PC of the instruction currently in D.
- d_imm26  in  26  immediate field of the D instruction.
- rs_val  in  32  forwarded rs value, used for JR.
- im_addr  out  IM_AW  word address to the IM.
- im_rdata  in  32  instruction returned by the IM, combinational.
- pc  out  32  current fetch PC.
- addr_err  out  1  current PC misaligned or outside the IM window.
- fd_instr  out  32  registered instruction.
- fd_pc  out  32  registered PC of fd_instr.
- fd_valid  out  1  fd_instr is a real instruction (0 = bubble).

Behaviour:
- Clock and reset: one clock domain. On a clk edge with reset=0: pc=RESET_PC, fd_instr=0, fd_pc=0, fd_valid=0.
- IM address: im_addr = (pc - IM_BASE)[IM_AW+1:2], 32-bit subtraction, truncated.
- addr_err (combinational) = (pc[1:0]!=0) or pc<IM_BASE or pc>=IM_BASE+(4<<IM_AW).
- Redirect targets, all 32-bit wrap arithmetic:
  - BR: d_pc+4+{sext(d_imm26[15:0]),2'b00}.
  - J: {(d_pc+4)[31:28], d_imm26, 2'b00}.
  - JR: rs_val, unmodified; misalignment is reported later through addr_err.
- redirect = (npc_op==J) | (npc_op==JR) | (npc_op==BR & br_cond).
- Per-edge priority: reset > stall > redirect > sequential.
  - stall=1: pc, fd_instr, fd_pc, fd_valid all hold. Any redirect in that cycle is ignored; D re-presents it once the stall drops.
  - redirect: pc<=target. F/D loads a bubble (fd_instr=0, fd_pc=pc, fd_valid=0), which squashes the wrong-path fetch. See the DELAY_SLOT_EN exception below.
  - sequential: pc<=pc+4. F/D loads {im_rdata, pc, 1}.
  - addr_err=1 in a non-stalled cycle: F/D loads a bubble (fd_instr=0, fd_valid=0) and pc still advances per the rules above.
- Latency: the instruction at PC p is visible on fd_* exactly one edge after pc==p, provided that edge is not stalled.
- Wrap: pc+4 at 32'hFFFF_FFFC wraps to 0; addr_err then asserts.
- Reset asserted mid-stall or mid-redirect: reset wins and all state returns to reset values on that edge.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS delay slot): a redirect does not squash the fetch. F/D loads {im_rdata, pc, 1} as in the sequential case while pc<=target. BR/J target base stays d_pc+4.
- Undefined: squash behaviour exactly as described in Behaviour.

Decomposition:
- Package ifu_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR 2-bit localparams.
  - Default RESET_PC/IM_BASE.
  - Bubble encoding 32'h0000_0000 (sll $0,$0,0).
- One natural sub-module: ifu_npc_calc, combinational. Takes npc_op, br_cond, d_pc, d_imm26, rs_val and outputs {redirect, target}.
- The top level keeps the PC and F/D registers, stall/priority logic and addr_err.

Test Plan:
- Reset then 3 free-running edges, IM words 0..2 = 0x3C010001, 0x34210002, 0x00000000:
  - im_addr steps 0,1,2.
  - fd_pc goes 0x3000, 0x3004, 0x3008 with fd_valid=1.
  - fd_instr equals each word.
- BR with d_pc=0x3004, imm=0xFFFF, br_cond=1 → next pc=0x3004, fd_valid=0. Repeat with br_cond=0 → pc+4 and a valid fetch.
- J with d_pc=0x3010, imm26=0x0000C05 → pc=0x0000_3014. JR with rs_val=0x3002 → pc=0x3002, addr_err=1, next F/D is a bubble.
- stall held for 3 cycles while npc_op=J → pc and fd_* unchanged. Release stall with npc_op=J still presented → redirect taken on the first unstalled edge.
- reset driven low during a stall at pc=0x3040 → on that edge pc=0x3000 and fd_valid=0.
- Build with DELAY_SLOT_EN, J redirect at pc=0x3008 → fd_pc=0x3008, fd_valid=1, and pc=target on the same edge.

Source files
------------

// File: rtl/ifu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared constants for the instruction-fetch stage: next-PC opcode
//            encodings, default reset/IM base addresses, bubble encoding and
//            a branch-offset helper.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Redirect request encodings presented by the decode stage
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // Default address map
  localparam logic [31:0] IFU_RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IFU_IM_BASE_DEF  = 32'h0000_3000;

  // Bubble instruction: sll $0,$0,0
  localparam logic [31:0] IFU_BUBBLE = 32'h0000_0000;

  // Sign-extend a 16-bit branch offset and convert words to bytes
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_npc_calc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifu_npc_calc
// Brief    : Combinational redirect decision and target computation for the
//            fetch stage (branch, jump-immediate, jump-register).
// Revision : 1.0 - initial release
// ============================================================================
module ifu_npc_calc
  import ifu_pkg::*;
(
  input  logic [1:0]  npc_op_i,
  input  logic        br_cond_i,
  input  logic [31:0] d_pc_i,
  input  logic [25:0] d_imm26_i,
  input  logic [31:0] rs_val_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  // Branch and jump targets are relative to the instruction after the one in D
  logic [31:0] w_link_pc;
  assign w_link_pc = d_pc_i + 32'd4;

  // Select redirect flag and target from the decode-stage request
  always_comb begin
    redirect_o = 1'b0;
    target_o   = w_link_pc;
    case (npc_op_i)
      NPC_BR: begin
        redirect_o = br_cond_i;
        target_o   = w_link_pc + br_offset(d_imm26_i[15:0]);
      end
      NPC_J: begin
        redirect_o = 1'b1;
        target_o   = {w_link_pc[31:28], d_imm26_i, 2'b00};
      end
      NPC_JR: begin
        // Passed through untouched; a misaligned value surfaces via addr_err
        redirect_o = 1'b1;
        target_o   = rs_val_i;
      end
      default: begin
        redirect_o = 1'b0;
        target_o   = w_link_pc;
      end
    endcase
  end

endmodule : ifu_npc_calc
`default_nettype wire

// File: rtl/ifu_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_stage
// Brief    : Instruction-fetch stage. Owns the PC, drives the IM word address,
//            and registers the returned instruction into the F/D register.
//            Optional macro DELAY_SLOT_EN: when defined, a redirect keeps the
//            instruction fetched in the redirect cycle (MIPS delay slot);
//            otherwise that fetch is squashed into a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_stage
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IFU_IM_BASE_DEF,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       npc_op,
  input  logic             br_cond,
  input  logic [31:0]      d_pc,
  input  logic [25:0]      d_imm26,
  input  logic [31:0]      rs_val,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc,
  output logic             addr_err,
  output logic [31:0]      fd_instr,
  output logic [31:0]      fd_pc,
  output logic             fd_valid
);

  // First byte address past the IM window, kept 33 bits wide so a window
  // touching the top of the address space cannot overflow
  localparam logic [32:0] C_IM_END = {1'b0, IM_BASE} + (33'd4 << IM_AW);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_valid_q, fd_valid_d;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_squash;
  logic [31:0] w_pc_off;
  logic        w_unused_pc_off;

  ifu_npc_calc u_npc_calc (
    .npc_op_i   (npc_op),
    .br_cond_i  (br_cond),
    .d_pc_i     (d_pc),
    .d_imm26_i  (d_imm26),
    .rs_val_i   (rs_val),
    .redirect_o (w_redirect),
    .target_o   (w_target)
  );

  // IM word address: byte offset into the window, truncated to IM_AW words
  assign w_pc_off        = pc_q - IM_BASE;
  assign im_addr         = w_pc_off[IM_AW+1:2];
  assign w_unused_pc_off = ^{w_pc_off[31:IM_AW+2], w_pc_off[1:0]};

  assign addr_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) ||
                    ({1'b0, pc_q} >= C_IM_END);

`ifdef DELAY_SLOT_EN
  // Delay slot: the instruction fetched alongside a redirect still executes
  assign w_squash = 1'b0;
`else
  // The fetch issued in the redirect cycle is on the wrong path
  assign w_squash = w_redirect;
`endif

  // Next-state selection: stall holds everything, else redirect or step by 4
  always_comb begin
    pc_d       = pc_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    fd_valid_d = fd_valid_q;
    if (!stall) begin
      pc_d    = w_redirect ? w_target : (pc_q + 32'd4);
      fd_pc_d = pc_q;
      if (addr_err || w_squash) begin
        fd_instr_d = IFU_BUBBLE;
        fd_valid_d = 1'b0;
      end else begin
        fd_instr_d = im_rdata;
        fd_valid_d = 1'b1;
      end
    end
  end

  // PC and F/D pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      fd_instr_q <= IFU_BUBBLE;
      fd_pc_q    <= 32'h0000_0000;
      fd_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      fd_valid_q <= fd_valid_d;
    end
  end

  assign pc       = pc_q;
  assign fd_instr = fd_instr_q;
  assign fd_pc    = fd_pc_q;
  assign fd_valid = fd_valid_q;

endmodule : ifu_fetch_stage
`default_nettype wire

// File: tb/tb_ifu_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_stage
// Brief    : Directed self-checking bench for ifu_fetch_stage with a
//            behavioural IM and a scoreboard of expected post-edge state.
//            Honours DELAY_SLOT_EN for the redirect fetch behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_stage;
  import ifu_pkg::*;

  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef DELAY_SLOT_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, br_cond;
  logic [1:0]  npc_op;
  logic [31:0] d_pc, rs_val, im_rdata, pc, fd_instr, fd_pc;
  logic [25:0] d_imm26;
  logic [11:0] im_addr;
  logic        addr_err, fd_valid;

  logic [31:0] mem [0:4095];
  assign im_rdata = mem[im_addr];

  always #5 clk = ~clk;

  ifu_fetch_stage #(
    .RESET_PC (RST_PC),
    .IM_BASE  (BASE),
    .IM_AW    (12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_op   (npc_op),
    .br_cond  (br_cond),
    .d_pc     (d_pc),
    .d_imm26  (d_imm26),
    .rs_val   (rs_val),
    .im_addr  (im_addr),
    .im_rdata (im_rdata),
    .pc       (pc),
    .addr_err (addr_err),
    .fd_instr (fd_instr),
    .fd_pc    (fd_pc),
    .fd_valid (fd_valid)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] fpc;
    logic        fv;
    logic        aerr;
    logic [11:0] ia;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc, m_instr, m_fpc;
  logic        m_fv;

  function automatic logic m_aerr(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p < 32'h0000_3000) || (p >= 32'h0000_7000);
  endfunction

  function automatic logic [11:0] m_ia(input logic [31:0] p);
    logic [31:0] o;
    o = p - BASE;
    return o[13:2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, clock, compare
  task automatic step(input string tag, input logic rst_n, input logic st,
                      input logic [1:0] op, input logic bc, input logic [31:0] dpc,
                      input logic [25:0] imm, input logic [31:0] rs);
    logic [31:0] tgt;
    logic        redir;
    exp_t        e, got;
    reset = rst_n; stall = st; npc_op = op; br_cond = bc;
    d_pc = dpc; d_imm26 = imm; rs_val = rs;
    redir = 1'b0;
    tgt   = 32'h0;
    if (op == NPC_BR) begin
      redir = bc;
      tgt   = dpc + 32'd4 + (32'($signed(imm[15:0])) << 2);
    end else if (op == NPC_J) begin
      redir = 1'b1;
      tgt   = ((dpc + 32'd4) & 32'hF000_0000) | (32'(imm) << 2);
    end else if (op == NPC_JR) begin
      redir = 1'b1;
      tgt   = rs;
    end
    if (!rst_n) begin
      m_pc = RST_PC; m_instr = 32'h0; m_fpc = 32'h0; m_fv = 1'b0;
    end else if (!st) begin
      m_fpc = m_pc;
      if (m_aerr(m_pc) || (redir && !DS)) begin
        m_instr = 32'h0; m_fv = 1'b0;
      end else begin
        m_instr = mem[m_ia(m_pc)]; m_fv = 1'b1;
      end
      m_pc = redir ? tgt : m_pc + 32'd4;
    end
    e = '{pc: m_pc, instr: m_instr, fpc: m_fpc, fv: m_fv,
          aerr: m_aerr(m_pc), ia: m_ia(m_pc)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".pc"},       pc,               got.pc);
    chk({tag, ".fd_instr"}, fd_instr,         got.instr);
    chk({tag, ".fd_pc"},    fd_pc,            got.fpc);
    chk({tag, ".fd_valid"}, 32'(fd_valid),    32'(got.fv));
    chk({tag, ".addr_err"}, 32'(addr_err),    32'(got.aerr));
    chk({tag, ".im_addr"},  32'(im_addr),     32'(got.ia));
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b1, 1'b0, NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0);
  endtask

  task automatic jr(input string tag, input logic [31:0] rs);
    step(tag, 1'b1, 1'b0, NPC_JR, 1'b0, 32'h0, 26'h0, rs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h3C01_0001;
    mem[1] = 32'h3421_0002;
    mem[2] = 32'h0000_0000;
    reset = 1'b0; stall = 1'b0; npc_op = NPC_SEQ; br_cond = 1'b0;
    d_pc = 32'h0; d_imm26 = 26'h0; rs_val = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_fpc = 32'h0; m_fv = 1'b0;
    @(negedge clk);

    // Reset state
    step("reset", 1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_valid", 32'(fd_valid), 32'h0);
    chk("rst_im_addr", 32'(im_addr), 32'h0);

    // Free-running sequential fetch
    seq("seq0");
    chk("seq0_fdpc", fd_pc, 32'h3000);
    chk("seq0_instr", fd_instr, 32'h3C01_0001);
    chk("seq0_im_addr", 32'(im_addr), 32'h1);
    seq("seq1");
    chk("seq1_fdpc", fd_pc, 32'h3004);
    chk("seq1_instr", fd_instr, 32'h3421_0002);
    chk("seq1_im_addr", 32'(im_addr), 32'h2);
    seq("seq2");
    chk("seq2_fdpc", fd_pc, 32'h3008);
    chk("seq2_valid", 32'(fd_valid), 32'h1);

    // Branch taken to itself (offset -1 word), then not taken
    step("br_t", 1'b1, 1'b0, NPC_BR, 1'b1, 32'h3004, 26'h000FFFF, 32'h0);
    chk("br_t_pc", pc, 32'h3004);
    chk("br_t_valid", 32'(fd_valid), 32'(DS));
    step("br_nt", 1'b1, 1'b0, NPC_BR, 1'b0, 32'h3004, 26'h000FFFF, 32'h0);
    chk("br_nt_pc", pc, 32'h3008);
    chk("br_nt_valid", 32'(fd_valid), 32'h1);

    // Jump-immediate and jump-register (misaligned)
    step("j", 1'b1, 1'b0, NPC_J, 1'b0, 32'h3010, 26'h0000C05, 32'h0);
    chk("j_pc", pc, 32'h3014);
    seq("j_seq");
    jr("jr_mis", 32'h3002);
    chk("jr_mis_pc", pc, 32'h3002);
    chk("jr_mis_aerr", 32'(addr_err), 32'h1);
    seq("aerr_bubble");
    chk("aerr_bubble_valid", 32'(fd_valid), 32'h0);
    jr("jr_3040", 32'h3040);

    // Stall with a pending jump, then release
    for (int i = 0; i < 3; i++) begin
      step("stall_j", 1'b1, 1'b1, NPC_J, 1'b0, 32'h3010, 26'h0000C05, 32'h0);
      chk("stall_pc", pc, 32'h3040);
    end
    step("unstall_j", 1'b1, 1'b0, NPC_J, 1'b0, 32'h3010, 26'h0000C05, 32'h0);
    chk("unstall_pc", pc, 32'h3014);
    chk("unstall_fdpc", fd_pc, 32'h3040);

    // Reset asserted while stalled
    jr("jr_3040b", 32'h3040);
    seq("pre_stall");
    jr("jr_3040c", 32'h3040);
    step("stall1", 1'b1, 1'b1, NPC_J, 1'b0, 32'h3010, 26'h0000C05, 32'h0);
    step("rst_in_stall", 1'b0, 1'b1, NPC_J, 1'b0, 32'h3010, 26'h0000C05, 32'h0);
    chk("rst_in_stall_pc", pc, 32'h3000);
    chk("rst_in_stall_valid", 32'(fd_valid), 32'h0);

    // Address-space wrap and IM window edges
    jr("jr_top", 32'hFFFF_FFFC);
    seq("wrap");
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_aerr", 32'(addr_err), 32'h1);
    jr("jr_last", 32'h6FFC);
    chk("last_aerr", 32'(addr_err), 32'h0);
    chk("last_im_addr", 32'(im_addr), 32'hFFF);
    seq("past_end");
    chk("past_end_instr", fd_instr, 32'hA500_0FFF);
    chk("past_end_aerr", 32'(addr_err), 32'h1);
    jr("below", 32'h2FFC);
    chk("below_aerr", 32'(addr_err), 32'h1);

    // Redirect from pc=0x3008 (delay-slot behaviour depends on build)
    step("reset2", 1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0);
    seq("ds_seq0");
    seq("ds_seq1");
    step("ds_j", 1'b1, 1'b0, NPC_J, 1'b0, 32'h3010, 26'h0000C05, 32'h0);
    chk("ds_fdpc", fd_pc, 32'h3008);
    chk("ds_valid", 32'(fd_valid), 32'(DS));
    chk("ds_pc", pc, 32'h3014);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ifu_fetch_stage
`default_nettype wire
